// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// ALU operations, FSM states, mux selects and the control-word struct.
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctl_e;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11
    } state_e;

    localparam logic [1:0] SRCB_RDB     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        alu_ctl_e   alu_control;
    } ctrl_t;

    // Control word shown while reset is held: FETCH selects, every enable off.
    function automatic ctrl_t reset_ctrl();
        ctrl_t c;
        c             = '0;
        c.alu_src_b   = SRCB_FOUR;
        c.alu_control = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle control unit (master) and the data path (slave).
interface multicycle_control_if #(parameter int CNT_W = 32);
    logic [5:0]       Opcode;
    logic [5:0]       Funct;
    logic             Zero;
    logic             PCWrite;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             IorD;
    logic             RegWrite;
    logic             RegDst;
    logic             MemToReg;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic [3:0]       ALUControl;
    logic             Illegal;
    logic [3:0]       State;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        input  Opcode, Funct, Zero,
        output PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst,
               MemToReg, ALUSrcA, ALUSrcB, PCSource, ALUControl, Illegal,
               State, InstrCount
    );

    modport slave (
        output Opcode, Funct, Zero,
        input  PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst,
               MemToReg, ALUSrcA, ALUSrcB, PCSource, ALUControl, Illegal,
               State, InstrCount
    );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct decoder: maps Funct to an ALU operation and flags unsupported functs.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output alu_ctl_e   alu_control,
    output logic       illegal
);
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            FN_NOR:  alu_control = ALU_NOR;
            default: illegal     = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/memory/
// writeback, output decode, and a retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    ctrl_t            ctl;
    logic             illegal;
    logic             retire;
    alu_ctl_e         dec_alu_control;
    logic             dec_illegal;

    alu_decoder u_alu_decoder (
        .funct       (bus.Funct),
        .alu_control (dec_alu_control),
        .illegal     (dec_illegal)
    );

    always_comb begin
        state_d = S_FETCH;
        ctl     = '0;
        illegal = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read    = 1'b1;
                ctl.ir_write    = 1'b1;
                ctl.alu_src_b   = SRCB_FOUR;
                ctl.alu_control = ALU_ADD;
                ctl.pc_source   = PCSRC_ALU;
                ctl.pc_write    = 1'b1;
                state_d         = S_DECODE;
            end
            S_DECODE: begin
                ctl.alu_src_b   = SRCB_IMM_SH2;
                ctl.alu_control = ALU_ADD;
                case (bus.Opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_IMM;
                ctl.alu_control = ALU_ADD;
                state_d         = (bus.Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.i_or_d   = 1'b1;
                state_d      = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.mem_to_reg = 1'b1;
                retire         = 1'b1;
            end
            S_MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.i_or_d    = 1'b1;
                retire        = 1'b1;
            end
            S_R_EXEC: begin
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_RDB;
                ctl.alu_control = dec_alu_control;
                illegal         = dec_illegal;
                state_d         = dec_illegal ? S_FETCH : S_R_WB;
            end
            S_R_WB: begin
                ctl.reg_write = 1'b1;
                ctl.reg_dst   = 1'b1;
                retire        = 1'b1;
            end
            S_BRANCH: begin
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_RDB;
                ctl.alu_control = ALU_SUB;
                ctl.pc_source   = PCSRC_ALUOUT;
                ctl.pc_write    = bus.Zero;
                retire          = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_IMM;
                ctl.alu_control = ALU_ADD;
                state_d         = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctl.reg_write = 1'b1;
                retire        = 1'b1;
            end
            S_JUMP: begin
                ctl.pc_source = PCSRC_JUMP;
                ctl.pc_write  = 1'b1;
                retire        = 1'b1;
            end
            default: ;
        endcase

        // Reset overrides the state decode so no write fires in the abort cycle.
        if (reset) begin
            ctl     = reset_ctrl();
            illegal = 1'b0;
            retire  = 1'b0;
        end
        instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, retire};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign bus.PCWrite    = ctl.pc_write;
    assign bus.IRWrite    = ctl.ir_write;
    assign bus.MemRead    = ctl.mem_read;
    assign bus.MemWrite   = ctl.mem_write;
    assign bus.IorD       = ctl.i_or_d;
    assign bus.RegWrite   = ctl.reg_write;
    assign bus.RegDst     = ctl.reg_dst;
    assign bus.MemToReg   = ctl.mem_to_reg;
    assign bus.ALUSrcA    = ctl.alu_src_a;
    assign bus.ALUSrcB    = ctl.alu_src_b;
    assign bus.PCSource   = ctl.pc_source;
    assign bus.ALUControl = ctl.alu_control;
    assign bus.Illegal    = illegal;
    assign bus.State      = state_q;
    assign bus.InstrCount = instr_count_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a 4-bit instruction counter so wrap is reachable.
module tb_multicycle_control;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_control_if #(.CNT_W(4)) bus ();

    multicycle_control #(.CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.Opcode = 6'b000000;
        bus.Funct  = 6'b100000;
        bus.Zero   = 1'b0;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_state", 32'(bus.State), 32'd0);
            check("rst_cnt", 32'(bus.InstrCount), 32'd0);
            check("rst_pcwrite", 32'(bus.PCWrite), 32'd0);
            check("rst_irwrite", 32'(bus.IRWrite), 32'd0);
            check("rst_regwrite", 32'(bus.RegWrite), 32'd0);
            check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        end
        check("rst_srcb", 32'(bus.ALUSrcB), 32'd1);
        check("rst_aluctl", 32'(bus.ALUControl), 32'd2);
        reset = 1'b0;
        #1;
        check("fetch_irwrite", 32'(bus.IRWrite), 32'd1);
        check("fetch_pcwrite", 32'(bus.PCWrite), 32'd1);
        check("fetch_memread", 32'(bus.MemRead), 32'd1);

        // lw: 0,1,2,3,4,0
        bus.Opcode = 6'b100011;
        tick(); check("lw_s1", 32'(bus.State), 32'd1);
        check("lw_dec_srcb", 32'(bus.ALUSrcB), 32'd3);
        tick(); check("lw_s2", 32'(bus.State), 32'd2);
        check("lw_addr_srcb", 32'(bus.ALUSrcB), 32'd2);
        tick(); check("lw_s3", 32'(bus.State), 32'd3);
        check("lw_rd_iord", 32'(bus.IorD), 32'd1);
        check("lw_rd_regwrite", 32'(bus.RegWrite), 32'd0);
        tick(); check("lw_s4", 32'(bus.State), 32'd4);
        check("lw_wb_regwrite", 32'(bus.RegWrite), 32'd1);
        check("lw_wb_memtoreg", 32'(bus.MemToReg), 32'd1);
        tick(); check("lw_s0", 32'(bus.State), 32'd0);
        check("lw_cnt", 32'(bus.InstrCount), 32'd1);
        check("lw_fetch_memtoreg", 32'(bus.MemToReg), 32'd0);

        // R-type sub then slt: 0,1,6,7,0
        bus.Opcode = 6'b000000;
        bus.Funct  = 6'b100010;
        tick(); check("sub_s1", 32'(bus.State), 32'd1);
        tick(); check("sub_s6", 32'(bus.State), 32'd6);
        check("sub_aluctl", 32'(bus.ALUControl), 32'b0110);
        tick(); check("sub_s7", 32'(bus.State), 32'd7);
        check("sub_regdst", 32'(bus.RegDst), 32'd1);
        check("sub_regwrite", 32'(bus.RegWrite), 32'd1);
        tick(); check("sub_s0", 32'(bus.State), 32'd0);
        check("sub_cnt", 32'(bus.InstrCount), 32'd2);
        bus.Funct = 6'b101010;
        tick(); tick(); check("slt_s6", 32'(bus.State), 32'd6);
        check("slt_aluctl", 32'(bus.ALUControl), 32'b0111);
        tick(); tick(); check("slt_cnt", 32'(bus.InstrCount), 32'd3);

        // beq taken then not taken: 0,1,8,0
        bus.Opcode = 6'b000100;
        bus.Zero   = 1'b1;
        tick(); tick(); check("beq1_s8", 32'(bus.State), 32'd8);
        check("beq1_pcwrite", 32'(bus.PCWrite), 32'd1);
        check("beq1_pcsrc", 32'(bus.PCSource), 32'd1);
        check("beq1_aluctl", 32'(bus.ALUControl), 32'b0110);
        tick(); check("beq1_s0", 32'(bus.State), 32'd0);
        check("beq1_cnt", 32'(bus.InstrCount), 32'd4);
        bus.Zero = 1'b0;
        tick(); tick(); check("beq0_s8", 32'(bus.State), 32'd8);
        check("beq0_pcwrite", 32'(bus.PCWrite), 32'd0);
        tick(); check("beq0_cnt", 32'(bus.InstrCount), 32'd5);

        // Illegal opcode: 0,1,0 with a pulse in DECODE
        bus.Opcode = 6'b111111;
        check("ill_fetch_flag", 32'(bus.Illegal), 32'd0);
        tick(); check("ill_s1", 32'(bus.State), 32'd1);
        check("ill_op_flag", 32'(bus.Illegal), 32'd1);
        tick(); check("ill_s0", 32'(bus.State), 32'd0);
        check("ill_op_cnt", 32'(bus.InstrCount), 32'd5);

        // Illegal funct: 0,1,6,0 with no write
        bus.Opcode = 6'b000000;
        bus.Funct  = 6'b000001;
        tick(); check("illf_dec_flag", 32'(bus.Illegal), 32'd0);
        tick(); check("illf_s6", 32'(bus.State), 32'd6);
        check("illf_flag", 32'(bus.Illegal), 32'd1);
        check("illf_regwrite", 32'(bus.RegWrite), 32'd0);
        tick(); check("illf_s0", 32'(bus.State), 32'd0);
        check("illf_cnt", 32'(bus.InstrCount), 32'd5);

        // addi: 0,1,9,10,0
        bus.Opcode = 6'b001000;
        tick(); tick(); check("addi_s9", 32'(bus.State), 32'd9);
        tick(); check("addi_s10", 32'(bus.State), 32'd10);
        check("addi_regwrite", 32'(bus.RegWrite), 32'd1);
        check("addi_regdst", 32'(bus.RegDst), 32'd0);
        tick(); check("addi_cnt", 32'(bus.InstrCount), 32'd6);

        // sw aborted by reset in MEM_WRITE
        bus.Opcode = 6'b101011;
        tick(); tick(); tick(); check("sw_s5", 32'(bus.State), 32'd5);
        check("sw_memwrite", 32'(bus.MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_memwrite", 32'(bus.MemWrite), 32'd0);
        tick(); check("abort_state", 32'(bus.State), 32'd0);
        check("abort_cnt", 32'(bus.InstrCount), 32'd0);
        reset = 1'b0;

        // 16 jumps wrap the 4-bit counter
        bus.Opcode = 6'b000010;
        for (int i = 0; i < 16; i++) begin
            tick(); tick();
            if (i == 0) begin
                check("j_s11", 32'(bus.State), 32'd11);
                check("j_pcsrc", 32'(bus.PCSource), 32'd2);
                check("j_pcwrite", 32'(bus.PCWrite), 32'd1);
            end
            tick();
            if (i == 14) check("j_cnt15", 32'(bus.InstrCount), 32'd15);
        end
        check("j_wrap", 32'(bus.InstrCount), 32'd0);
        check("j_end_state", 32'(bus.State), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
